// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
`timescale 1ns/1ps
package bcd2bin_pkg;

  localparam int DIGIT_COUNT           = 4;
  localparam int BCD_DIGIT_WIDTH       = 4;
  localparam int BCD_WIDTH             = 16;
  localparam int BCD_MAX_DIGIT         = 9;
  localparam int BCD_CORRECT_THRESHOLD = 8;
  localparam int BCD_CORRECT_VALUE     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic has_invalid_digit(input logic [BCD_WIDTH-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (bcd[i*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH] > BCD_DIGIT_WIDTH'(BCD_MAX_DIGIT)) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd2bin_converter_4_bcd_digit_correct.sv
// Reverse double-dabble digit correction: a shifted BCD digit that reads 8 or
// more carried a half-ten from the digit above, so 3 is taken off.
`timescale 1ns/1ps
module bcd_digit_correct
  import bcd2bin_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_DIGIT_WIDTH'(BCD_CORRECT_THRESHOLD))
                 ? digit_i - BCD_DIGIT_WIDTH'(BCD_CORRECT_VALUE)
                 : digit_i;

endmodule

// File: rtl/bcd2bin_converter_4.sv
// Sequential 4-digit BCD to binary converter, one reverse double-dabble step per clock.
// Define BCD2BIN_DIGIT_CHECK_EN to flag digits above 9 on Error.
`timescale 1ns/1ps
module bcd2bin_converter_4
  import bcd2bin_pkg::*;
#(
  parameter int OUTPUT_BIT_WIDTH = 14
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Start,
  input  logic [3:0]                  Digit3,
  input  logic [3:0]                  Digit2,
  input  logic [3:0]                  Digit1,
  input  logic [3:0]                  Digit0,
  output logic                        Ready,
  output logic                        Done,
  output logic [OUTPUT_BIT_WIDTH-1:0] Output,
  output logic                        Overflow,
  output logic                        Error
);

  localparam int CNT_WIDTH = $clog2(OUTPUT_BIT_WIDTH + 1);

  state_t                      state_q, state_d;
  logic [BCD_WIDTH-1:0]        bcd_q, bcd_d;
  logic [OUTPUT_BIT_WIDTH-1:0] bin_q, bin_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [OUTPUT_BIT_WIDTH-1:0] out_q, out_d;
  logic                        ovf_q, ovf_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic                        inv_q, inv_d;
  logic                        err_q, err_d;
`endif

  logic [BCD_WIDTH-1:0]        shift_bcd;
  logic [BCD_WIDTH-1:0]        corr_bcd;
  logic [OUTPUT_BIT_WIDTH-1:0] shift_bin;
  logic                        last_shift;

  assign shift_bcd  = bcd_q >> 1;
  assign shift_bin  = {bcd_q[0], bin_q[OUTPUT_BIT_WIDTH-1:1]};
  assign last_shift = (cnt_q == CNT_WIDTH'(OUTPUT_BIT_WIDTH));

  for (genvar g = 0; g < DIGIT_COUNT; g++) begin : g_corr
    bcd_digit_correct u_corr (
      .digit_i(shift_bcd[g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH]),
      .digit_o(corr_bcd[g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH])
    );
  end

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path through the case infers a latch.
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    inv_d   = inv_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = SHIFT;
          bcd_d   = {Digit3, Digit2, Digit1, Digit0};
          bin_d   = '0;
          cnt_d   = '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          inv_d   = has_invalid_digit({Digit3, Digit2, Digit1, Digit0});
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // The edge after the final shift only publishes the result.
        if (last_shift) begin
          state_d = DONE;
          out_d   = bin_q;
          ovf_d   = |bcd_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_d   = inv_q;
          if (inv_q) begin
            out_d = '0;
            ovf_d = 1'b0;
          end
`endif
        end else begin
          bcd_d = corr_bcd;
          bin_d = shift_bin;
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      inv_q   <= inv_d;
      err_q   <= err_d;
`endif
    end
  end

  assign Ready    = (state_q != SHIFT);
  assign Done     = (state_q == DONE);
  assign Output   = out_q;
  assign Overflow = ovf_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign Error    = err_q;
`else
  assign Error    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_converter_4.sv
// Self-checking bench for bcd2bin_converter_4 at widths 14 and 10, against a decimal-arithmetic model.
`timescale 1ns/1ps
module tb_bcd2bin_converter_4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  dg3 = '0, dg2 = '0, dg1 = '0, dg0 = '0;
  logic        rdy, done, ovf, err;
  logic [13:0] out14;
  logic        rdy10, done10, ovf10, err10;
  logic [9:0]  out10;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd2bin_converter_4 #(.OUTPUT_BIT_WIDTH(14)) dut (
    .Clk(clk), .Rst(rst), .Start(start),
    .Digit3(dg3), .Digit2(dg2), .Digit1(dg1), .Digit0(dg0),
    .Ready(rdy), .Done(done), .Output(out14), .Overflow(ovf), .Error(err)
  );

  bcd2bin_converter_4 #(.OUTPUT_BIT_WIDTH(10)) dut10 (
    .Clk(clk), .Rst(rst), .Start(start),
    .Digit3(dg3), .Digit2(dg2), .Digit1(dg1), .Digit0(dg0),
    .Ready(rdy10), .Done(done10), .Output(out10), .Overflow(ovf10), .Error(err10)
  );

  // Reference: decimal value of the digits, reduced modulo 2^w.
  function automatic void model(input logic [3:0] d3, d2, d1, d0, input int w,
                                output logic [13:0] o, output logic ov, output logic er);
    int v;
    v  = int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0);
    er = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    er = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
`endif
    if (er) begin
      o  = '0;
      ov = 1'b0;
    end else begin
      o  = 14'(v % (1 << w));
      ov = (v >= (1 << w));
    end
  endfunction

  function automatic logic cur_done(input bit use10);
    return use10 ? done10 : done;
  endfunction

  // Called at a negedge: presents digits with Start for exactly one rising edge.
  task automatic issue(input logic [3:0] d3, d2, d1, d0);
    dg3 = d3; dg2 = d2; dg1 = d1; dg0 = d0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until Done is seen (bounded).
  task automatic wait_done(input bit use10, input int n0, output int lat,
                           output logic [13:0] o, output logic ov, output logic er);
    int n;
    n = n0;
    while (!cur_done(use10) && n < 60) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    o   = use10 ? {4'b0, out10} : out14;
    ov  = use10 ? ovf10 : ovf;
    er  = use10 ? err10 : err;
  endtask

  task automatic do_conv(input logic [3:0] d3, d2, d1, d0, input bit use10, output int lat,
                         output logic [13:0] o, output logic ov, output logic er);
    issue(d3, d2, d1, d0);
    wait_done(use10, 0, lat, o, ov, er);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", rdy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (out14 !== 14'd0) begin miscompares++; $display("FAIL reset_output: got %0d expected 0", out14); end
    vectors++; if ({ovf, err} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b expected 00", {ovf, err}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if ({rdy, done} !== 2'b10) begin miscompares++; $display("FAIL reset_idle: got %b expected 10", {rdy, done}); end
  endtask

  task automatic test_basic();
    logic [15:0] tbl [5] = '{16'h0000, 16'h9999, 16'h1234, 16'h9000, 16'h0001};
    int lat; logic [13:0] o, eo; logic ov, eov, er, eer;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      do_conv(tbl[i][15:12], tbl[i][11:8], tbl[i][7:4], tbl[i][3:0], 1'b0, lat, o, ov, er);
      model(tbl[i][15:12], tbl[i][11:8], tbl[i][7:4], tbl[i][3:0], 14, eo, eov, eer);
      vectors++; if (lat !== 15) begin miscompares++; $display("FAIL basic_latency[%h]: got %0d expected 15", tbl[i], lat); end
      vectors++; if (o !== eo) begin miscompares++; $display("FAIL basic_output[%h]: got %0d expected %0d", tbl[i], o, eo); end
      vectors++; if ({ov, er} !== {eov, eer}) begin miscompares++; $display("FAIL basic_flags[%h]: got %b expected %b", tbl[i], {ov, er}, {eov, eer}); end
      vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL basic_ready_done[%h]: got %b expected 1", tbl[i], rdy); end
      @(negedge clk);
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse[%h]: got %b expected 0", tbl[i], done); end
    end
  endtask

  task automatic test_start_ignored();
    int n, dones, first; logic [13:0] got;
    dones = 0; first = -1; got = '0;
    @(negedge clk);
    dg3 = 4'd1; dg2 = 4'd2; dg1 = 4'd3; dg0 = 4'd4;
    start = 1'b1;
    @(negedge clk);
    dg3 = 4'd5; dg2 = 4'd5; dg1 = 4'd5; dg0 = 4'd5;
    n = 0;
    repeat (40) begin
      if (done) begin
        dones++;
        if (first < 0) begin first = n; got = out14; end
      end
      start = !rdy;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    vectors++; if (dones !== 1) begin miscompares++; $display("FAIL ignored_done_count: got %0d expected 1", dones); end
    vectors++; if (first !== 15) begin miscompares++; $display("FAIL ignored_latency: got %0d expected 15", first); end
    vectors++; if (got !== 14'd1234) begin miscompares++; $display("FAIL ignored_output: got %0d expected 1234", got); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [13:0] o; logic ov, er;
    @(negedge clk);
    do_conv(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, lat, o, ov, er);
    vectors++; if (o !== 14'd1234) begin miscompares++; $display("FAIL b2b_first: got %0d expected 1234", o); end
    issue(4'd5, 4'd6, 4'd7, 4'd8);
    repeat (5) @(negedge clk);
    vectors++; if (out14 !== 14'd1234) begin miscompares++; $display("FAIL b2b_output_held: got %0d expected 1234", out14); end
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy: got %b expected 0", rdy); end
    wait_done(1'b0, 5, lat, o, ov, er);
    vectors++; if (lat !== 15) begin miscompares++; $display("FAIL b2b_latency2: got %0d expected 15", lat); end
    vectors++; if (o !== 14'd5678) begin miscompares++; $display("FAIL b2b_second: got %0d expected 5678", o); end
    do_conv(4'd0, 4'd0, 4'd0, 4'd7, 1'b0, lat, o, ov, er);
    vectors++; if (lat !== 15) begin miscompares++; $display("FAIL b2b_latency3: got %0d expected 15", lat); end
    vectors++; if (o !== 14'd7) begin miscompares++; $display("FAIL b2b_third: got %0d expected 7", o); end
  endtask

  task automatic test_reset_abort();
    int dones, lat; logic [13:0] o; logic ov, er;
    dones = 0;
    @(negedge clk);
    issue(4'd7, 4'd7, 4'd7, 4'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if ({rdy, done} !== 2'b10) begin miscompares++; $display("FAIL abort_handshake: got %b expected 10", {rdy, done}); end
    vectors++; if (out14 !== 14'd0) begin miscompares++; $display("FAIL abort_output: got %0d expected 0", out14); end
    vectors++; if ({ovf, err} !== 2'b00) begin miscompares++; $display("FAIL abort_flags: got %b expected 00", {ovf, err}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) dones++;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    do_conv(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, lat, o, ov, er);
    vectors++; if (lat !== 15) begin miscompares++; $display("FAIL abort_next_latency: got %0d expected 15", lat); end
    vectors++; if (o !== 14'd42) begin miscompares++; $display("FAIL abort_next_output: got %0d expected 42", o); end
  endtask

  task automatic test_width10();
    int lat; logic [13:0] o; logic ov, er;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_conv(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, lat, o, ov, er);
    vectors++; if (lat !== 11) begin miscompares++; $display("FAIL w10_latency: got %0d expected 11", lat); end
    vectors++; if (o !== 14'd210) begin miscompares++; $display("FAIL w10_output: got %0d expected 210", o); end
    vectors++; if ({ov, er} !== 2'b10) begin miscompares++; $display("FAIL w10_flags: got %b expected 10", {ov, er}); end
    vectors++; if (rdy10 !== 1'b1) begin miscompares++; $display("FAIL w10_ready: got %b expected 1", rdy10); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_digit_check();
    int lat; logic [13:0] o; logic ov, er;
    @(negedge clk);
    do_conv(4'd0, 4'd0, 4'd10, 4'd3, 1'b0, lat, o, ov, er);
    vectors++; if (lat !== 15) begin miscompares++; $display("FAIL digchk_latency: got %0d expected 15", lat); end
`ifdef BCD2BIN_DIGIT_CHECK_EN
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL digchk_error: got %b expected 1", er); end
    vectors++; if ({o, ov} !== 15'd0) begin miscompares++; $display("FAIL digchk_zeroed: got %0d/%b expected 0/0", o, ov); end
`else
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL digchk_error_tied: got %b expected 0", er); end
`endif
    do_conv(4'd0, 4'd0, 4'd1, 4'd5, 1'b0, lat, o, ov, er);
    vectors++; if ({o, ov, er} !== {14'd15, 2'b00}) begin miscompares++; $display("FAIL digchk_recover: got %0d/%b/%b expected 15/0/0", o, ov, er); end
  endtask

  task automatic test_random();
    int lat; logic [13:0] o, eo; logic ov, eov, er, eer;
    logic [3:0] d [4];
    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < 4; j++) begin
        d[j] = 4'($urandom_range(0, 9));
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if ($urandom_range(0, 7) == 0) d[j] = 4'($urandom_range(10, 15));
`endif
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      do_conv(d[3], d[2], d[1], d[0], 1'b0, lat, o, ov, er);
      model(d[3], d[2], d[1], d[0], 14, eo, eov, eer);
      vectors++; if (lat !== 15) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected 15", i, lat); end
      vectors++; if ({o, ov, er} !== {eo, eov, eer}) begin miscompares++;
        $display("FAIL rand_result[%0d] digits %0d%0d%0d%0d: got %0d/%b/%b expected %0d/%b/%b",
                 i, d[3], d[2], d[1], d[0], o, ov, er, eo, eov, eer); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_width10();
    test_digit_check();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
